// File: rtl/vector_ctrl_seq.sv
// Registered instruction decoder and memory-beat sequencer for the scalar/vector datapath.
// Latency: one cycle from acceptance to bundle. Memory ops hold the bundle for 1 or BEATS beats.
// Backpressure: in_ready drops for the whole memory sequence, and mem_ready stalls the current beat.
module vector_ctrl_seq #(
  parameter  int VLEN  = 8,
  parameter  int LANES = 2,
  localparam int BEATS = VLEN / LANES,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [1:0]    instruction_type,
  input  logic [1:0]    func,
  input  logic          imm,
  input  logic          vector,
  input  logic          mem_ready,
  output logic          in_ready,
  output logic          ctrl_valid,
  output logic          JumpI,
  output logic          JumpCI,
  output logic          JumpCD,
  output logic          MemToReg,
  output logic          MemRead,
  output logic          MemWrite,
  output logic          ImmSrc,
  output logic          VectorOp,
  output logic          ALUSrc1,
  output logic          ALUSrc3,
  output logic          RegVWrite,
  output logic          RegSWrite,
  output logic [1:0]    ALUOp,
  output logic [1:0]    ALUSrc2,
  output logic [BW-1:0] beat_idx,
  output logic          illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

  typedef struct packed {
    logic       jump_i;
    logic       jump_ci;
    logic       jump_cd;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       imm_src;
    logic       vector_op;
    logic       alu_src1;
    logic       alu_src3;
    logic       reg_v_write;
    logic       reg_s_write;
    logic [1:0] alu_op;
    logic [1:0] alu_src2;
  } ctrl_t;

  state_t        state, state_n;
  ctrl_t         bundle_q, bundle_n, dec;
  logic          cv_q, cv_n, ill_q, ill_n;
  logic          dec_ill, dec_mem, accept;
  logic [BW-1:0] beat_q, beat_n, last_q, last_n;

  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    dec_mem = 1'b0;
    case (instruction_type)
      2'b00: begin
        if (!imm && func == 2'b00) begin
          dec.jump_ci  = 1'b1;
          dec.imm_src  = 1'b1;
          dec.alu_src2 = 2'b11;
        end else if (!imm && func == 2'b01) begin
          dec.jump_cd  = 1'b1;
          dec.imm_src  = 1'b1;
          dec.alu_src2 = 2'b11;
        end else if (imm && func == 2'b00) begin
          dec.jump_i = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      2'b01: begin
        dec.imm_src   = 1'b1;
        dec.alu_src2  = 2'b10;
        dec.vector_op = vector;
        dec.alu_src1  = vector;
        dec_mem       = 1'b1;
        case (func)
          2'b00: dec.mem_write = 1'b1;
          2'b01: begin
            dec.mem_read    = 1'b1;
            dec.mem_to_reg  = 1'b1;
            dec.reg_v_write = vector;
            dec.reg_s_write = !vector;
          end
          default: begin
            dec_ill = 1'b1;
            dec_mem = 1'b0;
          end
        endcase
      end
      2'b10: begin
        if (imm) begin
          dec.alu_op      = func;
          dec.alu_src2    = 2'b10;
          dec.imm_src     = 1'b1;
          dec.reg_s_write = 1'b1;
        end else if (!vector) begin
          if (func == 2'b00) begin
            dec.alu_src2    = 2'b01;
            dec.reg_s_write = 1'b1;
          end else begin
            dec_ill = 1'b1;
          end
        end else if (func != 2'b11) begin
          dec.alu_op      = func;
          dec.alu_src3    = 1'b1;
          dec.vector_op   = 1'b1;
          dec.reg_v_write = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_ready = (state != MEM);
  assign accept   = instr_valid && in_ready;

  always_comb begin
    state_n  = state;
    bundle_n = bundle_q;
    cv_n     = cv_q;
    ill_n    = 1'b0;
    beat_n   = beat_q;
    last_n   = last_q;
    case (state)
      MEM: begin
        if (mem_ready) begin
          if (beat_q == last_q) begin
            state_n  = IDLE;
            bundle_n = '0;
            cv_n     = 1'b0;
            beat_n   = '0;
          end else begin
            beat_n = beat_q + BW'(1);
          end
        end
      end
      default: begin
        // IDLE and EXEC behave identically: EXEC only lasts while instructions keep arriving
        bundle_n = '0;
        cv_n     = 1'b0;
        beat_n   = '0;
        state_n  = IDLE;
        if (accept) begin
          if (dec_ill) begin
            ill_n = 1'b1;
          end else begin
            bundle_n = dec;
            cv_n     = 1'b1;
            if (dec_mem) begin
              state_n = MEM;
              last_n  = vector ? BW'(BEATS - 1) : '0;
            end else begin
              state_n = EXEC;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bundle_q <= '0;
      cv_q     <= 1'b0;
      ill_q    <= 1'b0;
      beat_q   <= '0;
      last_q   <= '0;
    end else begin
      state    <= state_n;
      bundle_q <= bundle_n;
      cv_q     <= cv_n;
      ill_q    <= ill_n;
      beat_q   <= beat_n;
      last_q   <= last_n;
    end
  end

  // Load write strobes follow the beat actually taken, so a stalled beat writes nothing
  logic wb_gate;
  assign wb_gate = (state != MEM) || mem_ready;

  assign ctrl_valid = cv_q;
  assign illegal    = ill_q;
  assign beat_idx   = beat_q;
  assign JumpI      = bundle_q.jump_i;
  assign JumpCI     = bundle_q.jump_ci;
  assign JumpCD     = bundle_q.jump_cd;
  assign MemToReg   = bundle_q.mem_to_reg;
  assign MemRead    = bundle_q.mem_read;
  assign MemWrite   = bundle_q.mem_write;
  assign ImmSrc     = bundle_q.imm_src;
  assign VectorOp   = bundle_q.vector_op;
  assign ALUSrc1    = bundle_q.alu_src1;
  assign ALUSrc3    = bundle_q.alu_src3;
  assign RegVWrite  = bundle_q.reg_v_write & wb_gate;
  assign RegSWrite  = bundle_q.reg_s_write & wb_gate;
  assign ALUOp      = bundle_q.alu_op;
  assign ALUSrc2    = bundle_q.alu_src2;

endmodule

// File: tb/tb_vector_ctrl_seq.sv
// Bench for vector_ctrl_seq: a decode table plus hand-written memory/reset sequences, with each
// cycle's expected outputs pushed to a scoreboard queue and popped when the following cycle is sampled.
module tb_vector_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [1:0] instruction_type = 2'b00;
  logic [1:0] func = 2'b00;
  logic       imm = 1'b0;
  logic       vector = 1'b0;
  logic       mem_ready = 1'b0;
  logic       in_ready, ctrl_valid, illegal;
  logic       JumpI, JumpCI, JumpCD, MemToReg, MemRead, MemWrite, ImmSrc, VectorOp;
  logic       ALUSrc1, ALUSrc3, RegVWrite, RegSWrite;
  logic [1:0] ALUOp, ALUSrc2, beat_idx;

  always #5 clk = ~clk;

  vector_ctrl_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction_type(instruction_type),
    .func(func), .imm(imm), .vector(vector), .mem_ready(mem_ready), .in_ready(in_ready),
    .ctrl_valid(ctrl_valid), .JumpI(JumpI), .JumpCI(JumpCI), .JumpCD(JumpCD),
    .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite), .ImmSrc(ImmSrc),
    .VectorOp(VectorOp), .ALUSrc1(ALUSrc1), .ALUSrc3(ALUSrc3), .RegVWrite(RegVWrite),
    .RegSWrite(RegSWrite), .ALUOp(ALUOp), .ALUSrc2(ALUSrc2), .beat_idx(beat_idx),
    .illegal(illegal)
  );

  // ctl bit order: JumpI JumpCI JumpCD MemToReg | MemRead MemWrite ImmSrc VectorOp |
  //                ALUSrc1 ALUSrc3 RegVWrite RegSWrite | ALUOp[1:0] ALUSrc2[1:0]
  typedef struct packed {
    logic       ir;
    logic       cv;
    logic       ill;
    logic [1:0] beat;
    logic [15:0] ctl;
  } obs_t;

  typedef struct packed {
    logic [1:0]  t;
    logic [1:0]  f;
    logic        im;
    logic        vc;
    logic [15:0] ctl;
    logic        ill;
  } vec_t;

  typedef struct {
    string nm;
    obs_t  o;
  } exp_t;

  localparam logic [15:0] C_DIMM   = 16'b0000_0010_0001_1110;
  localparam logic [15:0] C_LDV    = 16'b0001_1011_1010_0010;
  localparam logic [15:0] C_LDV_NW = 16'b0001_1011_1000_0010;
  localparam logic [15:0] C_LDS    = 16'b0001_1010_0001_0010;
  localparam logic [15:0] C_LDS_NW = 16'b0001_1010_0000_0010;
  localparam logic [15:0] C_STV    = 16'b0000_0111_1000_0010;
  localparam logic [15:0] C_STS    = 16'b0000_0110_0000_0010;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  vec_t tbl[14];
  obs_t idle_o;

  function automatic obs_t mk(input logic ir, input logic cv, input logic ill,
                              input logic [1:0] b, input logic [15:0] c);
    obs_t o;
    o.ir = ir; o.cv = cv; o.ill = ill; o.beat = b; o.ctl = c;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ir   = in_ready;
    o.cv   = ctrl_valid;
    o.ill  = illegal;
    o.beat = beat_idx;
    o.ctl  = {JumpI, JumpCI, JumpCD, MemToReg, MemRead, MemWrite, ImmSrc, VectorOp,
              ALUSrc1, ALUSrc3, RegVWrite, RegSWrite, ALUOp, ALUSrc2};
    return o;
  endfunction

  task automatic push(input string nm, input obs_t o);
    exp_t e;
    e.nm = nm;
    e.o  = o;
    exp_q.push_back(e);
  endtask

  task automatic check_one();
    exp_t e;
    obs_t got;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got an output cycle, required an expectation");
    end else begin
      e   = exp_q.pop_front();
      got = sample();
      if (got !== e.o) begin
        n_bad++;
        $display("FAIL %s: got ir=%b cv=%b ill=%b beat=%0d ctl=%b, want ir=%b cv=%b ill=%b beat=%0d ctl=%b",
                 e.nm, got.ir, got.cv, got.ill, got.beat, got.ctl,
                 e.o.ir, e.o.cv, e.o.ill, e.o.beat, e.o.ctl);
      end
    end
  endtask

  // Drive one cycle, check this cycle's outputs, and queue what the next cycle must show.
  task automatic step(input logic r, input logic v, input logic [1:0] t, input logic [1:0] f,
                      input logic im, input logic vc, input logic mr,
                      input obs_t nxt, input string nm);
    @(posedge clk);
    #1;
    rst = r; instr_valid = v; instruction_type = t; func = f;
    imm = im; vector = vc; mem_ready = mr;
    #1;
    check_one();
    push(nm, nxt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b10, 2'b01, 1'b1, 1'b1, 16'b0000_0010_0001_0110, 1'b0};
    tbl[1]  = '{2'b10, 2'b00, 1'b0, 1'b0, 16'b0000_0000_0001_0001, 1'b0};
    tbl[2]  = '{2'b10, 2'b10, 1'b0, 1'b1, 16'b0000_0001_0110_1000, 1'b0};
    tbl[3]  = '{2'b10, 2'b00, 1'b0, 1'b1, 16'b0000_0001_0110_0000, 1'b0};
    tbl[4]  = '{2'b00, 2'b00, 1'b0, 1'b0, 16'b0100_0010_0000_0011, 1'b0};
    tbl[5]  = '{2'b00, 2'b01, 1'b0, 1'b0, 16'b0010_0010_0000_0011, 1'b0};
    tbl[6]  = '{2'b00, 2'b00, 1'b1, 1'b0, 16'b1000_0000_0000_0000, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[8]  = '{2'b10, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[9]  = '{2'b10, 2'b11, 1'b0, 1'b1, 16'h0000, 1'b1};
    tbl[10] = '{2'b00, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[11] = '{2'b00, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[12] = '{2'b01, 2'b10, 1'b0, 1'b1, 16'h0000, 1'b1};
    tbl[13] = '{2'b10, 2'b11, 1'b1, 1'b0, C_DIMM, 1'b0};
    idle_o  = mk(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);

    repeat (2) @(posedge clk);
    push("reset_state", idle_o);
    step(1, 1, 2'b10, 2'b11, 1, 0, 1, idle_o, "rst_ignores_instr");
    step(0, 1, 2'b10, 2'b11, 1, 0, 1, mk(1, 1, 0, 0, C_DIMM), "data_imm");

    for (int i = 0; i < 14; i++)
      step(0, 1, tbl[i].t, tbl[i].f, tbl[i].im, tbl[i].vc, 1,
           mk(1, !tbl[i].ill, tbl[i].ill, 0, tbl[i].ill ? 16'h0000 : tbl[i].ctl),
           $sformatf("tbl%0d", i));
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, idle_o, "tbl_idle");

    // Vector load, mem_ready high; the instruction offered during the last beat is ignored
    step(0, 1, 2'b01, 2'b01, 0, 1, 1, mk(0, 1, 0, 0, C_LDV), "vld_b0");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, mk(0, 1, 0, 1, C_LDV), "vld_b1");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, mk(0, 1, 0, 2, C_LDV), "vld_b2");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, mk(0, 1, 0, 3, C_LDV), "vld_b3");
    step(0, 1, 2'b00, 2'b00, 1, 0, 1, idle_o, "vld_done_ignored_instr");

    // Vector load stalled two cycles on beat 1
    step(0, 1, 2'b01, 2'b01, 0, 1, 1, mk(0, 1, 0, 0, C_LDV), "stl_b0");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, mk(0, 1, 0, 1, C_LDV_NW), "stl_b1_wait1");
    step(0, 0, 2'b00, 2'b00, 0, 0, 0, mk(0, 1, 0, 1, C_LDV_NW), "stl_b1_wait2");
    step(0, 0, 2'b00, 2'b00, 0, 0, 0, mk(0, 1, 0, 1, C_LDV), "stl_b1_go");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, mk(0, 1, 0, 2, C_LDV), "stl_b2");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, mk(0, 1, 0, 3, C_LDV), "stl_b3");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, idle_o, "stl_done");

    // Reset during beat 2 of a vector store, then a single-beat scalar store
    step(0, 1, 2'b01, 2'b00, 0, 1, 1, mk(0, 1, 0, 0, C_STV), "vst_b0");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, mk(0, 1, 0, 1, C_STV), "vst_b1");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, mk(0, 1, 0, 2, C_STV), "vst_b2");
    step(1, 0, 2'b00, 2'b00, 0, 0, 1, idle_o, "rst_mid_mem");
    step(0, 1, 2'b01, 2'b00, 0, 0, 1, mk(0, 1, 0, 0, C_STS), "sst_b0");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, idle_o, "sst_done");

    // Scalar load with one stall cycle, then issue in the first ready cycle
    step(0, 1, 2'b01, 2'b01, 0, 0, 1, mk(0, 1, 0, 0, C_LDS_NW), "sld_wait");
    step(0, 0, 2'b00, 2'b00, 0, 0, 0, mk(0, 1, 0, 0, C_LDS), "sld_go");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, idle_o, "sld_done");
    step(0, 1, 2'b10, 2'b11, 1, 0, 1, mk(1, 1, 0, 0, C_DIMM), "issue_after_mem");
    step(0, 0, 2'b00, 2'b00, 0, 0, 1, idle_o, "final_idle");

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
      check_one();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_ctrl_seq.md
# vector_ctrl_seq

Registered, multi-beat instruction control sequencer for the scalar/vector datapath. It decodes each 2-bit type / 2-bit func / imm / vector instruction into the datapath control bundle and registers the result. Memory instructions are sequenced over the memory port: vectors take VLEN/LANES beats, scalars one beat. While a memory sequence is in progress it back-pressures instruction issue. It sits between fetch/issue and the execute/memory stages and supersedes the purely combinational decoder.

## Interface
- VLEN, default 8: elements per vector register; must be a multiple of LANES.
- LANES, default 2: elements moved per memory beat.
- BEATS, derived VLEN/LANES: beats per vector memory op.
- BW, derived max(1, clog2(BEATS)): beat index width.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  instruction fields valid this cycle.
- instruction_type  in  2  00 control, 01 memory, 10 data, 11 reserved.
- func  in  2  sub-operation.
- imm  in  1  immediate form.
- vector  in  1  vector form.
- mem_ready  in  1  memory accepts the current beat.
- in_ready  out  1  sequencer accepts an instruction this cycle.
- ctrl_valid  out  1  control bundle valid this cycle.
- JumpI, JumpCI, JumpCD, MemToReg, MemRead, MemWrite, ImmSrc, VectorOp, ALUSrc1, ALUSrc3, RegVWrite, RegSWrite  out  1 each  datapath controls.
- ALUOp, ALUSrc2  out  2 each  datapath controls.
- beat_idx  out  BW  current memory beat; lanes beat_idx*LANES .. +LANES-1.
- illegal  out  1  one-cycle pulse for an undecodable instruction.

## Operation
- States: IDLE, EXEC, MEM.
- in_ready = (state != MEM). An instruction is accepted when instr_valid && in_ready.
- Accepting a non-memory instruction goes to EXEC for 1 cycle.
  - ctrl_valid = 1 and the decoded bundle is driven.
  - From EXEC, go back to IDLE, or stay in EXEC if another instruction is accepted the same cycle.
- Accepting a memory instruction goes to MEM, with beat_idx = 0 and last = vector ? BEATS-1 : 0.
- In MEM:
  - ctrl_valid = 1 and the bundle is held.
  - On mem_ready, beat_idx increments.
  - On mem_ready with beat_idx == last, go to IDLE.
- Decode, control type (00). All memory/register-write bits are 0; ALUOp = 00.
  - func 00, imm 0: JumpCI = 1, ImmSrc = 1, ALUSrc2 = 11.
  - func 01, imm 0: JumpCD = 1, ImmSrc = 1, ALUSrc2 = 11.
  - func 00, imm 1: JumpI = 1.
  - Any other combination is illegal.
- Decode, memory type (01). ImmSrc = 1, ALUSrc2 = 10, ALUOp = 00, VectorOp = vector, ALUSrc1 = vector.
  - func 00 (store): MemWrite = 1.
  - func 01 (load): MemRead = 1, MemToReg = 1; RegVWrite = vector, RegSWrite = !vector.
  - Loads assert the register-write bit only in cycles where mem_ready = 1.
  - func 1x is illegal.
- Decode, data type (10).
  - imm 1: ALUOp = func, ALUSrc2 = 10, ImmSrc = 1, RegSWrite = 1; vector is ignored.
  - imm 0, vector 0: func 00 only; ALUSrc2 = 01, ALUOp = 00, RegSWrite = 1.
  - imm 0, vector 1: func 00/01/10; ALUOp = func, ALUSrc2 = 00, ALUSrc3 = 1, VectorOp = 1, RegVWrite = 1.
  - Any other combination is illegal.
- Type 11 is illegal.
- Illegal instruction: accepted, illegal pulses for 1 cycle, ctrl_valid stays 0, state stays IDLE.
- Every control output not listed above is 0. No X values are driven.
- Whenever ctrl_valid = 0, all control outputs are 0.

## Timing
- All outputs are registered except in_ready.
- Reset value of every output: 0. The state resets to IDLE, so in_ready = 1 from the first cycle after reset.
- Latency: instruction accepted at edge t; the bundle is visible in cycle t+1.
- Non-memory instructions issue back-to-back, one per cycle.
- Memory op: the last beat accepted at edge c puts in_ready = 1 in cycle c+1, and the next instruction's bundle appears at c+2.
- A vector memory op with mem_ready tied high occupies BEATS cycles.
- mem_ready = 0 holds beat_idx and the bundle unchanged. There is no timeout.
- An instruction presented while in_ready = 0 is ignored; the issuer must hold it.
- rst wins over everything: mid-MEM it forces IDLE, beat_idx = 0 and all outputs 0 at the next edge, and the in-flight memory op is dropped.
- instr_valid is ignored in the same cycle as rst.

## Test plan
- Reset, then a data-immediate op (type 10, func 11, imm 1): next cycle ctrl_valid = 1, ALUOp = 11, ALUSrc2 = 10, ImmSrc = 1, RegSWrite = 1, all other bits 0.
- Vector load (type 01, func 01, vector 1), mem_ready = 1, defaults: 4 cycles with beat_idx 0,1,2,3, MemRead = MemToReg = RegVWrite = VectorOp = 1; in_ready = 0 until the last beat; in_ready = 1 the cycle after.
- Same load with mem_ready low for 2 cycles during beat 1: beat_idx holds at 1 and RegVWrite = 0 while stalled; the op completes after 6 cycles total.
- Back-to-back: JumpCI (00/00/imm 0), then JumpCD (00/01/imm 0), then JumpI (00/00/imm 1) on consecutive cycles: three consecutive bundles, each with exactly one jump bit set.
- Illegal instructions, type 11 and then type 10/func 01/imm 0/vector 0: each gives an illegal 1-cycle pulse with ctrl_valid = 0.
- rst asserted during beat 2 of a vector store: the next cycle all outputs are 0, in_ready = 1, beat_idx = 0; a following scalar store completes in 1 beat.
